// File: rtl/floo_vc_pkg.sv
// Shared types and helpers for the virtual-channel demultiplexer.
package floo_vc_pkg;

    localparam int unsigned MaxVirtChannels = 2;
    localparam int unsigned VcIdWidth = (MaxVirtChannels > 1) ? $clog2(MaxVirtChannels) : 1;

    typedef logic [VcIdWidth-1:0] vc_id_t;

    // A depth-1 FIFO still needs a one-bit pointer so the vector is never zero-width.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/floo_vc_demux_fifo.sv
// Single-VC flit FIFO: circular buffer with modulo-depth pointers and an occupancy counter.
module floo_vc_demux_fifo
    import floo_vc_pkg::*;
#(
    parameter int unsigned FifoDepth = 2,
    parameter type payload_t = logic [31:0]
) (
    input  logic     clk,
    input  logic     srst,
    input  logic     push,
    input  payload_t wdata,
    input  logic     pop,
    output logic     full,
    output logic     empty,
    output payload_t head
);

    localparam int unsigned PtrWidth = ptr_width(FifoDepth);
    localparam int unsigned CntWidth = $clog2(FifoDepth + 1);

    payload_t            mem_reg [FifoDepth];
    logic [PtrWidth-1:0] wr_ptr_reg;
    logic [PtrWidth-1:0] rd_ptr_reg;
    logic [CntWidth-1:0] cnt_reg;
    logic [CntWidth-1:0] cnt_next;
    logic                push_ok;
    logic                pop_ok;

    function automatic logic [PtrWidth-1:0] wrap_inc(input logic [PtrWidth-1:0] ptr);
        return (ptr == PtrWidth'(FifoDepth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full  = (cnt_reg == CntWidth'(FifoDepth));
    assign empty = (cnt_reg == '0);

    // Full is judged on current occupancy, so a pop never frees a slot for a same-cycle push.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign head = mem_reg[rd_ptr_reg];

    always_comb begin
        cnt_next = cnt_reg;
        case ({push_ok, pop_ok})
            2'b10:   cnt_next = cnt_reg + 1'b1;
            2'b01:   cnt_next = cnt_reg - 1'b1;
            default: cnt_next = cnt_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wrap_inc(wr_ptr_reg);
            end
            if (pop_ok) begin
                rd_ptr_reg <= wrap_inc(rd_ptr_reg);
            end
            cnt_reg <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !srst) begin
            mem_reg[wr_ptr_reg] <= wdata;
        end
    end

endmodule

// File: rtl/floo_vc_demux.sv
// Routes incoming flits into one FIFO per virtual channel; each VC drains independently.
// Define FLOO_VC_DEMUX_CREDIT_EN to add a registered per-VC credit_o pulse one cycle after each pop.
module floo_vc_demux
    import floo_vc_pkg::*;
#(
    parameter int unsigned NumVirtChannels = 2,
    parameter int unsigned DataWidth       = 32,
    parameter int unsigned FifoDepth       = 2,
    parameter type         payload_t       = logic [DataWidth-1:0]
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  payload_t                           data_i,
    input  logic [$clog2(NumVirtChannels)-1:0] vc_id_i,
    input  logic                               valid_i,
    output logic                               ready_o,
    output payload_t                           data_o [NumVirtChannels],
    output logic [NumVirtChannels-1:0]         valid_o,
    input  logic [NumVirtChannels-1:0]         ready_i
`ifdef FLOO_VC_DEMUX_CREDIT_EN
    ,
    output logic [NumVirtChannels-1:0]         credit_o
`endif
);

    localparam int unsigned IdWidth = $clog2(NumVirtChannels);
    localparam int unsigned IdSpan  = 2 ** IdWidth;

    logic [NumVirtChannels-1:0] push;
    logic [NumVirtChannels-1:0] pop;
    logic [NumVirtChannels-1:0] full;
    logic [NumVirtChannels-1:0] empty;
    logic [IdSpan-1:0]          full_ext;

    // Unused VC codes read as never-full, so such flits are accepted and dropped.
    genvar gi;
    generate
        for (gi = 0; gi < IdSpan; gi++) begin : g_full_ext
            if (gi < NumVirtChannels) begin : g_real
                assign full_ext[gi] = full[gi];
            end else begin : g_unused
                assign full_ext[gi] = 1'b0;
            end
        end
    endgenerate

    assign ready_o = !full_ext[vc_id_i];

    generate
        for (gi = 0; gi < NumVirtChannels; gi++) begin : g_vc
            assign push[gi]    = valid_i && (vc_id_i == IdWidth'(gi)) && !full[gi];
            assign valid_o[gi] = !empty[gi];
            assign pop[gi]     = valid_o[gi] && ready_i[gi];

            floo_vc_demux_fifo #(
                .FifoDepth (FifoDepth),
                .payload_t (payload_t)
            ) u_fifo (
                .clk   (clk_i),
                .srst  (rst_i),
                .push  (push[gi]),
                .wdata (data_i),
                .pop   (pop[gi]),
                .full  (full[gi]),
                .empty (empty[gi]),
                .head  (data_o[gi])
            );
        end
    endgenerate

`ifdef FLOO_VC_DEMUX_CREDIT_EN
    logic [NumVirtChannels-1:0] credit_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            credit_reg <= '0;
        end else begin
            credit_reg <= pop;
        end
    end

    assign credit_o = credit_reg;
`endif

endmodule

// File: tb/tb_floo_vc_demux.sv
// Self-checking bench for floo_vc_demux: directed scenarios then random traffic against a queue model.
module tb_floo_vc_demux;

    localparam int NVC   = 2;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [DW-1:0]  data_in;
    logic           vc_id;
    logic           valid_in;
    logic           ready_out;
    logic [DW-1:0]  data_out [NVC];
    logic [NVC-1:0] valid_out;
    logic [NVC-1:0] ready_in;
`ifdef FLOO_VC_DEMUX_CREDIT_EN
    logic [NVC-1:0] credit_out;
`endif

    always #5 clk = ~clk;

    floo_vc_demux #(
        .NumVirtChannels (NVC),
        .DataWidth       (DW),
        .FifoDepth       (DEPTH)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .data_i   (data_in),
        .vc_id_i  (vc_id),
        .valid_i  (valid_in),
        .ready_o  (ready_out),
        .data_o   (data_out),
        .valid_o  (valid_out),
        .ready_i  (ready_in)
`ifdef FLOO_VC_DEMUX_CREDIT_EN
        ,
        .credit_o (credit_out)
`endif
    );

    // Reference model: one queue per VC plus the credits owed for last cycle's pops.
    logic [DW-1:0]  mq [NVC][$];
    logic [NVC-1:0] credit_exp;
    int             n_checks = 0;
    int             n_pass   = 0;
    int             n_fail   = 0;
    int             credit1_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs to the model, then advance both.
    task automatic cycle(input logic vld, input int vc, input logic [DW-1:0] d,
                         input logic [NVC-1:0] rdy);
        logic           exp_ready;
        logic [NVC-1:0] pops;
        rst      = 1'b0;
        valid_in = vld;
        vc_id    = vc[0];
        data_in  = d;
        ready_in = rdy;
        #1;
        exp_ready = (mq[vc].size() < DEPTH);
        check($sformatf("ready_o vc%0d", vc), 64'(ready_out), 64'(exp_ready));
        pops = '0;
        for (int k = 0; k < NVC; k++) begin
            check($sformatf("valid_o[%0d]", k), 64'(valid_out[k]), 64'(mq[k].size() > 0));
            if (mq[k].size() > 0) begin
                check($sformatf("data_o[%0d]", k), 64'(data_out[k]), 64'(mq[k][0]));
                if (rdy[k]) pops[k] = 1'b1;
            end
        end
`ifdef FLOO_VC_DEMUX_CREDIT_EN
        check("credit_o", 64'(credit_out), 64'(credit_exp));
        if (credit_out[1]) credit1_cnt++;
`endif
        for (int k = 0; k < NVC; k++) begin
            if (pops[k]) void'(mq[k].pop_front());
        end
        if (vld && exp_ready) mq[vc].push_back(d);
        credit_exp = pops;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset with live traffic on every input to show reset-cycle pushes/pops are ignored.
    task automatic do_reset();
        rst      = 1'b1;
        valid_in = 1'b1;
        vc_id    = 1'b0;
        data_in  = 32'hDEAD_BEEF;
        ready_in = '1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NVC; k++) mq[k].delete();
        credit_exp = '0;
    endtask

    initial begin
        logic [DW-1:0] a, b, c;
        int            c1_start;
        a = 32'hA000_000A;
        b = 32'hB000_000B;
        c = 32'hC000_000C;
        rst        = 1'b1;
        valid_in   = 1'b0;
        vc_id      = 1'b0;
        data_in    = '0;
        ready_in   = '0;
        credit_exp = '0;
        @(posedge clk);
        @(negedge clk);
        do_reset();

        // Idle after reset, ready probed for both VC ids.
        cycle(1'b0, 0, '0, '0);
        cycle(1'b0, 1, '0, '0);

        // Fill VC0 while stalled, then drain in order.
        cycle(1'b1, 0, a, '0);
        cycle(1'b1, 0, b, '0);
        cycle(1'b0, 0, '0, '0);
        check("vc0_full_ready", 64'(ready_out), 64'(0));
        check("vc0_head_A", 64'(data_out[0]), 64'(a));
        cycle(1'b0, 0, '0, 2'b01);
        check("vc0_head_B", 64'(data_out[0]), 64'(b));
        cycle(1'b0, 0, '0, 2'b01);
        check("vc0_drained", 64'(valid_out[0]), 64'(0));

        // VC0 full and stalled must not block VC1.
        cycle(1'b1, 0, a, '0);
        cycle(1'b1, 0, b, '0);
        cycle(1'b1, 1, c, '0);
        check("vc1_head_C", 64'(data_out[1]), 64'(c));
        check("vc1_valid", 64'(valid_out[1]), 64'(1));

        // Pop and push on full VC0 in the same cycle: push refused, occupancy drops to 1.
        cycle(1'b1, 0, 32'h1234_5678, 2'b01);
        check("vc0_after_pop_head", 64'(data_out[0]), 64'(b));
        cycle(1'b0, 0, '0, 2'b11);
        check("vc0_empty_after", 64'(valid_out[0]), 64'(0));
        cycle(1'b0, 0, '0, '0);

        // Five pops on VC1, each expected to return one credit.
        c1_start = credit1_cnt;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1, 32'h0000_1000 + i, '0);
            cycle(1'b0, 1, '0, 2'b10);
        end
        cycle(1'b0, 0, '0, '0);
`ifdef FLOO_VC_DEMUX_CREDIT_EN
        check("vc1_credit_count", 64'(credit1_cnt - c1_start), 64'(5));
`endif

        // Reset with two flits buffered in VC0.
        cycle(1'b1, 0, a, '0);
        cycle(1'b1, 0, b, '0);
        do_reset();
        check("post_reset_valid", 64'(valid_out), 64'(0));
        cycle(1'b0, 0, '0, '0);

        // Random traffic, with occasional mid-run resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, NVC - 1)),
                      DW'($urandom()), NVC'($urandom()));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/floo_vc_demux.md
FLOO_VC_DEMUX -- requirements
Module: floo_vc_demux

Interface
REQ-001: Parameter NumVirtChannels, default 2, number of virtual channels; SHALL be >= 2.
REQ-002: Parameter DataWidth, default 32, flit payload width in bits.
REQ-003: Parameter FifoDepth, default 2, per-VC buffer depth in flits; SHALL be >= 1.
REQ-004: Parameter payload_t, default logic [DataWidth-1:0], payload type.
REQ-005: The block SHALL use one clock and a synchronous, active-high reset, with ports as follows.
  - clk_i  in  1  clock; all state updates on the rising edge.
  - rst_i  in  1  synchronous, active-high reset.
  - data_i  in  payload_t  incoming flit.
  - vc_id_i  in  $clog2(NumVirtChannels)  target VC of the incoming flit.
  - valid_i  in  1  incoming flit valid.
  - ready_o  out  1  flit accepted when valid_i and ready_o are both high.
  - data_o  out  NumVirtChannels x payload_t  per-VC head flit.
  - valid_o  out  NumVirtChannels  per-VC head valid.
  - ready_i  in  NumVirtChannels  per-VC consumer ready.
  - credit_o  out  NumVirtChannels  per-VC credit return pulse; present only with FLOO_VC_DEMUX_CREDIT_EN.

Function
REQ-006: The block SHALL keep one independent FIFO of FifoDepth entries per VC, with occupancy counter width $clog2(FifoDepth+1).
REQ-007: Push SHALL occur into FIFO[vc_id_i] when valid_i && ready_o.
REQ-008: ready_o SHALL equal !full[vc_id_i], combinational from vc_id_i and state, with no dependency on ready_i.
REQ-009: A full FIFO SHALL NOT accept a flit, even if it pops in the same cycle (no full-bypass).
REQ-010: Pop of VC v SHALL occur when valid_o[v] && ready_i[v]; valid_o[v] = !empty[v]; data_o[v] = head of FIFO[v].
REQ-011: Latency SHALL be exactly 1 cycle: a flit accepted in cycle N appears on valid_o in cycle N+1. There is no combinational input-to-output path.
REQ-012: On an empty FIFO, valid_o[v] SHALL be 0 and data_o[v] is don't-care (implementation drives the stored entry).
REQ-013: A simultaneous push and pop on the same non-full VC SHALL leave occupancy unchanged and preserve order.
REQ-014: A push to VC a and a pop from VC b in the same cycle SHALL be independent; each VC preserves FIFO order and there is no head-of-line blocking across VCs.
REQ-015: Read and write pointers SHALL wrap modulo FifoDepth; non-power-of-two depths are supported.
REQ-016: If vc_id_i >= NumVirtChannels (non-power-of-two NumVirtChannels), ready_o SHALL be 1 and the flit SHALL be discarded without state change.

Reset
REQ-017: While rst_i is high at a clock edge, all pointers and counters SHALL clear, valid_o = 0, and credit_o = 0.
REQ-018: ready_o SHALL be 1 in the first cycle after reset.
REQ-019: Reset asserted mid-operation SHALL discard all buffered flits; pops or pushes in a reset cycle SHALL have no effect.

Configuration
REQ-020: With FLOO_VC_DEMUX_CREDIT_EN defined, credit_o SHALL exist, and credit_o[v] SHALL pulse high for exactly one cycle, registered, in the cycle after each pop of VC v.
REQ-021: With FLOO_VC_DEMUX_CREDIT_EN defined, ready_o SHALL remain as specified, for assertion use only; the upstream sender is credit-based and never pushes to a full VC.
REQ-022: Without FLOO_VC_DEMUX_CREDIT_EN, the credit_o port and its logic SHALL be absent, and flow control SHALL rely solely on ready_o.

Structure
REQ-023: Package floo_vc_pkg SHALL hold vc_id_t (width $clog2(NumVirtChannels)) and a default MaxVirtChannels constant.
REQ-024: One sub-module, floo_vc_demux_fifo (per-VC FIFO with push, pop, full, empty and head data), SHALL be instantiated NumVirtChannels times via generate.

Verification
REQ-025: Reset, then idle: valid_o = 2'b00, ready_o = 1 for vc_id_i = 0 and 1; with the macro, credit_o = 0.
REQ-026: NumVirtChannels = 2, FifoDepth = 2; push A,B to VC0 with ready_i = 0: ready_o(vc0) = 0 after two pushes, valid_o[0] = 1 with data_o[0] = A; then ready_i[0] = 1 pops A then B in order.
REQ-027: VC0 full and stalled, push C to VC1: accepted, and valid_o[1] = 1 with data_o[1] = C one cycle later.
REQ-028: VC0 full while pop and push arrive in the same cycle: push rejected (ready_o = 0), occupancy becomes 1.
REQ-029: With the macro, 5 pops on VC1: exactly 5 single-cycle credit_o[1] pulses, each one cycle after its pop.
REQ-030: rst_i asserted with 2 flits buffered in VC0: the next cycle shows valid_o = 0, ready_o = 1, and no credit pulse.
